// File: rtl/pipestagereg.sv
// pipestagereg: valid/ready pipeline stage register with a 2-entry skid buffer,
// synchronous flush and bubble-gated control field.
module pipestagereg #(
  parameter int CWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int FLUSHDATA = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              invalid,
  output logic              inready,
  input  logic [CWIDTH-1:0] ctrlin,
  input  logic [DWIDTH-1:0] datain,
  output logic              outvalid,
  input  logic              outready,
  output logic [CWIDTH-1:0] ctrlout,
  output logic [DWIDTH-1:0] dataout,
  output logic [1:0]        count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            r_state, w_next;
  logic [CWIDTH-1:0] r_main_c, r_skid_c;
  logic [DWIDTH-1:0] r_main_d, r_skid_d;
  logic              w_acc, w_rel, w_ld_in, w_ld_skid, w_ld_fwd;
  assign outvalid = r_state != EMPTY;
  assign inready  = r_state != FULL;
  assign count    = r_state;
  assign ctrlout  = outvalid ? r_main_c : '0;
  assign dataout  = r_main_d;
  assign w_acc    = invalid & inready;
  assign w_rel    = outvalid & outready;
  always_comb begin
    w_next    = r_state;
    w_ld_in   = 1'b0;
    w_ld_skid = 1'b0;
    w_ld_fwd  = 1'b0;
    case (r_state)
      EMPTY: begin
        w_next  = w_acc ? ONE : EMPTY;
        w_ld_in = w_acc;
      end
      ONE: begin
        w_next    = (w_acc & ~w_rel) ? FULL : (~w_acc & w_rel) ? EMPTY : ONE;
        w_ld_in   = w_acc & w_rel;
        w_ld_skid = w_acc & ~w_rel;
      end
      FULL: begin
        w_next   = w_rel ? ONE : FULL;
        w_ld_fwd = w_rel;
      end
      default: w_next = EMPTY;
    endcase
    // a flush still lets the downstream transfer complete; it only kills what remains
    if (flush) begin
      w_next    = EMPTY;
      w_ld_in   = 1'b0;
      w_ld_skid = 1'b0;
      w_ld_fwd  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= EMPTY;
      r_main_c <= '0;
      r_main_d <= '0;
      r_skid_c <= '0;
      r_skid_d <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_in) begin
        r_main_c <= ctrlin;
        r_main_d <= datain;
      end else if (w_ld_fwd) begin
        r_main_c <= r_skid_c;
        r_main_d <= r_skid_d;
      end
      if (w_ld_skid) begin
        r_skid_c <= ctrlin;
        r_skid_d <= datain;
      end
      if (flush && FLUSHDATA != 0) begin
        r_main_d <= '0;
        r_skid_d <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipestagereg.sv
// tb_pipestagereg: directed vector table, streaming and multi-cycle sequences,
// then randomised valid/ready traffic against a reference FIFO model.
module tb_pipestagereg;
  localparam int FD = 0;
  logic        clk = 1'b0, rstn, flush, invalid, inready, outvalid, outready;
  logic [7:0]  ctrlin, ctrlout;
  logic [31:0] datain, dataout;
  logic [1:0]  count;
  int          total = 0, bad = 0;
  pipestagereg #(.CWIDTH(8), .DWIDTH(32), .FLUSHDATA(FD)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .invalid(invalid), .inready(inready),
    .ctrlin(ctrlin), .datain(datain), .outvalid(outvalid), .outready(outready),
    .ctrlout(ctrlout), .dataout(dataout), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rn, fl, iv; logic [7:0] ci; logic [31:0] di; logic ordy;
    logic ov, ir; logic [1:0] cnt; logic [7:0] co; logic [31:0] dout;
  } vec_t;
  vec_t vecs[$];
  logic [39:0] q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rn, fl, iv, input logic [7:0] ci, input logic [31:0] di, input logic ordy);
    rstn = rn; flush = fl; invalid = iv; ctrlin = ci; datain = di; outready = ordy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] f66, f88;
    f66 = FD ? 32'h0 : 32'h66;
    f88 = FD ? 32'h0 : 32'h88;
    //              rn fl iv  ci     di          ordy ov ir cnt co     dout
    vecs.push_back('{0, 0, 1, 8'hFF, 32'hDEAD,   1,   0, 1, 0, 8'h00, 32'h0});
    vecs.push_back('{1, 0, 0, 8'h00, 32'h0,      1,   0, 1, 0, 8'h00, 32'h0});
    vecs.push_back('{1, 0, 1, 8'hA5, 32'h1,      1,   1, 1, 1, 8'hA5, 32'h1});
    vecs.push_back('{1, 0, 1, 8'hA5, 32'h2,      1,   1, 1, 1, 8'hA5, 32'h2});
    vecs.push_back('{1, 0, 0, 8'h00, 32'h0,      1,   0, 1, 0, 8'h00, 32'h2});
    vecs.push_back('{1, 0, 1, 8'h3C, 32'h11,     0,   1, 1, 1, 8'h3C, 32'h11});
    vecs.push_back('{1, 0, 1, 8'h3D, 32'h22,     0,   1, 0, 2, 8'h3C, 32'h11});
    vecs.push_back('{1, 0, 1, 8'h3E, 32'h33,     0,   1, 0, 2, 8'h3C, 32'h11});
    vecs.push_back('{1, 0, 1, 8'h3E, 32'h33,     1,   1, 1, 1, 8'h3D, 32'h22});
    vecs.push_back('{1, 0, 1, 8'h3E, 32'h33,     1,   1, 1, 1, 8'h3E, 32'h33});
    vecs.push_back('{1, 0, 0, 8'h00, 32'h0,      1,   0, 1, 0, 8'h00, 32'h33});
    vecs.push_back('{1, 0, 1, 8'h01, 32'h66,     0,   1, 1, 1, 8'h01, 32'h66});
    vecs.push_back('{1, 0, 1, 8'h02, 32'h77,     0,   1, 0, 2, 8'h01, 32'h66});
    vecs.push_back('{1, 1, 1, 8'h04, 32'h44,     0,   0, 1, 0, 8'h00, f66});
    vecs.push_back('{1, 0, 0, 8'h00, 32'h0,      1,   0, 1, 0, 8'h00, f66});
    vecs.push_back('{1, 0, 1, 8'h05, 32'h88,     0,   1, 1, 1, 8'h05, 32'h88});
    vecs.push_back('{1, 1, 1, 8'h09, 32'h99,     1,   0, 1, 0, 8'h00, f88});
    vecs.push_back('{1, 0, 1, 8'h06, 32'hAA,     0,   1, 1, 1, 8'h06, 32'hAA});
    vecs.push_back('{1, 0, 1, 8'h07, 32'hBB,     0,   1, 0, 2, 8'h06, 32'hAA});
    vecs.push_back('{0, 0, 1, 8'h0C, 32'hCC,     0,   0, 1, 0, 8'h00, 32'h0});
    vecs.push_back('{1, 0, 1, 8'h08, 32'h55,     0,   1, 1, 1, 8'h08, 32'h55});
    vecs.push_back('{1, 0, 0, 8'h00, 32'h0,      1,   0, 1, 0, 8'h00, 32'h55});
    drive(1, 0, 0, 0, 0, 0);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].fl, vecs[i].iv, vecs[i].ci, vecs[i].di, vecs[i].ordy);
      tick();
      chk($sformatf("v%0d_outvalid", i), outvalid, vecs[i].ov);
      chk($sformatf("v%0d_inready", i), inready, vecs[i].ir);
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_ctrlout", i), ctrlout, vecs[i].co);
      chk($sformatf("v%0d_dataout", i), dataout, vecs[i].dout);
    end
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 1, 8'hA5, i, 1);
      tick();
      chk($sformatf("strm%0d_data", i), dataout, i);
      chk($sformatf("strm%0d_valid", i), outvalid, 1);
      chk($sformatf("strm%0d_ctrl", i), ctrlout, 8'hA5);
      chk($sformatf("strm%0d_cnt_le1", i), count <= 2'd1, 1);
    end
    drive(1, 0, 0, 0, 0, 1);
    tick();
    chk("strm_end_valid", outvalid, 0);
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl, acc, rel;
      logic [39:0] ent;
      iv   = $urandom_range(0, 99) < 60;
      ordy = $urandom_range(0, 99) < 55;
      fl   = $urandom_range(0, 99) < 2;
      ent  = {$urandom_range(0, 255), $urandom()};
      drive(1, fl, iv, ent[39:32], ent[31:0], ordy);
      acc = iv && q.size() < 2;
      rel = ordy && q.size() > 0;
      tick();
      if (rel) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) q.push_back(ent);
      if (!(outvalid === (q.size() > 0) && count === 2'(q.size()) && inready === (q.size() < 2))) begin
        chk($sformatf("rnd%0d_valid", c), outvalid, q.size() > 0);
        chk($sformatf("rnd%0d_count", c), count, q.size());
        chk($sformatf("rnd%0d_inready", c), inready, q.size() < 2);
      end else total++;
      if (q.size() > 0) begin
        chk($sformatf("rnd%0d_head", c), {ctrlout, dataout}, q[0][31:0]);
        if (ctrlout !== q[0][39:32]) chk($sformatf("rnd%0d_ctrl", c), ctrlout, q[0][39:32]);
      end else chk($sformatf("rnd%0d_bubble_ctrl", c), ctrlout, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
